// File: rtl/fx_fl_pkg.sv
// Shared definitions for the fixed/float converter stages.
// Holds the handshake FSM state encoding and the IEEE-754 single field widths.
package fx_fl_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MANT_W  = 23;
    localparam int unsigned FLOAT_W = 1 + EXP_W + MANT_W;

    localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StNorm = 2'd1,
        StPack = 2'd2,
        StDone = 2'd3
    } fx_fl_state_e;

endpackage

// File: rtl/fixed_to_float_dp.sv
// Datapath for the fixed-to-float converter.
// Holds sign / magnitude / exponent registers, the absolute-value loader, the one-bit
// normalising shifter and the result packer. Sequenced by strobes from the FSM.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   load_i             : capture sign and |fixed_i|, exponent <- bias
//   shr_i / shl_i      : shift magnitude right / left by one, adjust exponent
//   pack_i             : register the packed single-precision result
//   fixed_i            : two's complement operand
//   mag_zero_o         : magnitude is zero
//   mag_high_o         : magnitude has a bit above the integer-one position
//   mag_lead_o         : magnitude bit at the integer-one position
//   float_o            : registered IEEE-754 single result
module fixed_to_float_dp
    import fx_fl_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter int unsigned FRAC_W = 24
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               shr_i,
    input  logic               shl_i,
    input  logic               pack_i,
    input  logic [W-1:0]       fixed_i,
    output logic               mag_zero_o,
    output logic               mag_high_o,
    output logic               mag_lead_o,
    output logic [FLOAT_W-1:0] float_o
);

    logic               sign_q, sign_d;
    logic [W-1:0]       mag_q, mag_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [FLOAT_W-1:0] float_q, float_d;

    // Unsigned result, so the most negative input maps to 2^(W-1) without overflow.
    logic [W-1:0] fixed_abs;
    assign fixed_abs = fixed_i[W-1] ? ((~fixed_i) + W'(1)) : fixed_i;

    always_comb begin
        sign_d  = sign_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        float_d = float_q;
        if (load_i) begin
            sign_d = fixed_i[W-1];
            mag_d  = fixed_abs;
            exp_d  = EXP_BIAS;
        end else if (shr_i) begin
            mag_d = mag_q >> 1;
            exp_d = exp_q + EXP_W'(1);
        end else if (shl_i) begin
            mag_d = mag_q << 1;
            exp_d = exp_q - EXP_W'(1);
        end
        if (pack_i) begin
            // Zero always packs as +0; otherwise truncate below the 23 mantissa bits.
            if (mag_zero_o) begin
                float_d = '0;
            end else begin
                float_d = {sign_q, exp_q, mag_q[FRAC_W-1 -: MANT_W]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sign_q  <= 1'b0;
            mag_q   <= '0;
            exp_q   <= '0;
            float_q <= '0;
        end else begin
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            float_q <= float_d;
        end
    end

    assign mag_zero_o = (mag_q == '0);
    assign mag_high_o = |mag_q[W-1:FRAC_W+1];
    assign mag_lead_o = mag_q[FRAC_W];
    assign float_o    = float_q;

    // Bits below the mantissa field are truncated and never observed.
    if (FRAC_W > MANT_W) begin : gen_unused
        logic unused_mag_low;
        assign unused_mag_low = ^mag_q[FRAC_W-MANT_W-1:0];
    end

endmodule

// File: rtl/fixed_to_float_conv.sv
// Converts a signed fixed-point value back to IEEE-754 single precision.
// Normalises one bit per clock, then packs. Start/acknowledge/return-to-idle handshake.
//   CLK, RST_N    : clock, synchronous active-low reset
//   RST_FSM_FL    : return from DONE to IDLE (ignored elsewhere)
//   Begin_FSM_FL  : start request, sampled only in IDLE
//   FIXED         : signed fixed-point operand with FRAC_W fractional bits
//   FLOAT         : registered single-precision result, held until the next pack
//   ACK_FL        : high while in DONE
//   BUSY          : high while normalising or packing
module fixed_to_float_conv
    import fx_fl_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter int unsigned FRAC_W = 24
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         RST_FSM_FL,
    input  logic         Begin_FSM_FL,
    input  logic [W-1:0] FIXED,
    output logic [31:0]  FLOAT,
    output logic         ACK_FL,
    output logic         BUSY
);

    fx_fl_state_e state_q, state_d;

    logic load, shr, shl, pack;
    logic mag_zero, mag_high, mag_lead;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shr     = 1'b0;
        shl     = 1'b0;
        pack    = 1'b0;
        case (state_q)
            StIdle: begin
                if (Begin_FSM_FL) begin
                    load    = 1'b1;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                // One action per cycle: zero exits, oversize shifts right,
                // undersize shifts left, otherwise normalised.
                if (mag_zero) begin
                    state_d = StPack;
                end else if (mag_high) begin
                    shr = 1'b1;
                end else if (!mag_lead) begin
                    shl = 1'b1;
                end else begin
                    state_d = StPack;
                end
            end
            StPack: begin
                pack    = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                if (RST_FSM_FL) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign ACK_FL = (state_q == StDone);
    assign BUSY   = (state_q == StNorm) || (state_q == StPack);

    fixed_to_float_dp #(
        .W      (W),
        .FRAC_W (FRAC_W)
    ) u_dp (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .load_i     (load),
        .shr_i      (shr),
        .shl_i      (shl),
        .pack_i     (pack),
        .fixed_i    (FIXED),
        .mag_zero_o (mag_zero),
        .mag_high_o (mag_high),
        .mag_lead_o (mag_lead),
        .float_o    (FLOAT)
    );

endmodule

// File: tb/tb_fixed_to_float_conv.sv
// Self-checking bench for fixed_to_float_conv (W=32, FRAC_W=24).
// Directed cases plus random operands, checked against an arithmetic reference model.
module tb_fixed_to_float_conv;

    localparam int unsigned W      = 32;
    localparam int unsigned FRAC_W = 24;

    logic          clk;
    logic          rst_n;
    logic          rst_fsm;
    logic          begin_fsm;
    logic [W-1:0]  fixed_in;
    logic [31:0]   float_out;
    logic          ack;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    fixed_to_float_conv #(
        .W      (W),
        .FRAC_W (FRAC_W)
    ) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .RST_FSM_FL   (rst_fsm),
        .Begin_FSM_FL (begin_fsm),
        .FIXED        (fixed_in),
        .FLOAT        (float_out),
        .ACK_FL       (ack),
        .BUSY         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: value = FIXED / 2^FRAC_W. Float keeps the 23 bits after the leading one,
    // truncated; latency counts the accepting edge plus one edge per shift plus two.
    function automatic void model(input logic [31:0] x, output logic [31:0] f,
                                  output int lat);
        longint unsigned a;
        longint unsigned m;
        int p;
        int e;
        a = x[31] ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
        if (a == 0) begin
            f   = 32'h0;
            lat = 3;
            return;
        end
        p = 0;
        for (int i = 0; i < 40; i++) if (a[i]) p = i;
        e = 127 + p - int'(FRAC_W);
        if (p >= 23) m = a >> (p - 23);
        else         m = a << (23 - p);
        f   = {x[31], 8'(e), m[22:0]};
        lat = ((p > int'(FRAC_W)) ? (p - int'(FRAC_W)) : (int'(FRAC_W) - p)) + 3;
    endfunction

    // Runs one conversion from IDLE and leaves the DUT in DONE.
    task automatic run_conv(input string tag, input logic [31:0] x);
        logic [31:0] exp_f;
        int          exp_lat;
        int          edges;
        int          busy_cnt;
        model(x, exp_f, exp_lat);
        @(negedge clk);
        fixed_in  = x;
        begin_fsm = 1'b1;
        @(posedge clk);
        edges    = 1;
        busy_cnt = 0;
        @(negedge clk);
        begin_fsm = 1'b0;
        fixed_in  = $urandom;
        while (!ack && edges < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            edges++;
        end
        check_eq({tag, " ack"}, {31'd0, ack}, 32'd1);
        check_eq({tag, " latency"}, edges, exp_lat);
        check_eq({tag, " busy cycles"}, busy_cnt, exp_lat - 1);
        check_eq({tag, " float"}, float_out, exp_f);
        check_eq({tag, " busy in done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic return_idle();
        @(negedge clk);
        rst_fsm = 1'b1;
        @(negedge clk);
        rst_fsm = 1'b0;
        check_eq("idle ack", {31'd0, ack}, 32'd0);
    endtask

    initial begin
        logic [31:0] hold_f;
        logic [31:0] r;
        rst_n     = 1'b0;
        rst_fsm   = 1'b0;
        begin_fsm = 1'b0;
        fixed_in  = '0;
        repeat (3) @(negedge clk);
        check_eq("reset float", float_out, 32'h0);
        check_eq("reset ack", {31'd0, ack}, 32'd0);
        check_eq("reset busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_conv("one", 32'h0100_0000);
        check_eq("one const", float_out, 32'h3F80_0000);
        return_idle();
        run_conv("m2p5", 32'hFD80_0000);
        check_eq("m2p5 const", float_out, 32'hC020_0000);
        return_idle();
        run_conv("lsb", 32'h0000_0001);
        check_eq("lsb const", float_out, 32'h3380_0000);
        return_idle();
        run_conv("minneg", 32'h8000_0000);
        check_eq("minneg const", float_out, 32'hC300_0000);
        return_idle();
        run_conv("maxpos", 32'h7FFF_FFFF);
        check_eq("maxpos const", float_out, 32'h42FF_FFFF);

        // DONE holds result and acknowledge until told to return.
        hold_f = float_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold ack", {31'd0, ack}, 32'd1);
            check_eq("hold float", float_out, hold_f);
        end
        return_idle();

        run_conv("zero", 32'h0);
        check_eq("zero const", float_out, 32'h0);

        // Begin together with return-to-idle must not start a conversion.
        @(negedge clk);
        rst_fsm   = 1'b1;
        begin_fsm = 1'b1;
        fixed_in  = 32'h0100_0000;
        @(negedge clk);
        rst_fsm   = 1'b0;
        begin_fsm = 1'b0;
        check_eq("no start busy", {31'd0, busy}, 32'd0);
        check_eq("no start ack", {31'd0, ack}, 32'd0);
        @(negedge clk);
        check_eq("no start busy2", {31'd0, busy}, 32'd0);
        check_eq("no start float", float_out, 32'h0);

        // Reset in the middle of a long normalisation.
        run_conv("prev", 32'hFD80_0000);
        return_idle();
        @(negedge clk);
        fixed_in  = 32'h0000_0001;
        begin_fsm = 1'b1;
        @(negedge clk);
        begin_fsm = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mid busy before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid rst float", float_out, 32'h0);
        check_eq("mid rst ack", {31'd0, ack}, 32'd0);
        check_eq("mid rst busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        run_conv("after rst", 32'h0100_0000);
        check_eq("after rst const", float_out, 32'h3F80_0000);
        return_idle();

        for (int i = 0; i < 40; i++) begin
            r = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) r = -r;
            run_conv($sformatf("rand%0d", i), r);
            return_idle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
